// File: rtl/rsa_encrypt_sequencer.sv
// Feeds plaintext words one at a time through the 32-bit RSA encryptor core:
// clear, settle, compute, wait for done (or time out), then emit the ciphertext.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | ready for a word; key_load honoured here only
// CLEAR     | enc_clr_n held low for one cycle
// SETTLE    | clear released, wait SETTLE_CYCLES before requesting compute
// START     | enc_compute first high; timeout timer armed
// WAIT_DONE | compute held; sample enc_done or expire timeout
// OUTPUT    | ciphertext presented until ct_ready
module rsa_encrypt_sequencer #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             key_load,
  input  logic [31:0]      key_e,
  input  logic [31:0]      key_n,
  input  logic             msg_valid,
  input  logic [31:0]      msg_data,
  input  logic             msg_last,
  output logic             msg_ready,
  output logic             enc_clr_n,
  output logic             enc_compute,
  output logic [31:0]      enc_M,
  output logic [31:0]      enc_e,
  output logic [31:0]      enc_n,
  input  logic [31:0]      enc_C,
  input  logic             enc_done,
  output logic             ct_valid,
  output logic [31:0]      ct_data,
  output logic             ct_last,
  output logic             ct_err,
  input  logic             ct_ready,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] word_count
);

  localparam int TMAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, SETTLE, START, WAIT_DONE, OUTPUT
  } state_t;

  state_t            state, state_nxt;
  logic              last_q, last_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic [31:0]       m_nxt, e_nxt, n_nxt, ctd_nxt;
  logic              clr_nxt, comp_nxt, ctv_nxt, ctl_nxt, cte_nxt, terr_nxt;
  logic [CNT_W-1:0]  wc_nxt;

  assign msg_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    last_nxt  = last_q;
    timer_nxt = timer;
    m_nxt     = enc_M;
    e_nxt     = enc_e;
    n_nxt     = enc_n;
    clr_nxt   = 1'b1;
    comp_nxt  = enc_compute;
    ctv_nxt   = ct_valid;
    ctd_nxt   = ct_data;
    ctl_nxt   = ct_last;
    cte_nxt   = ct_err;
    terr_nxt  = timeout_err;
    wc_nxt    = word_count;
    case (state)
      IDLE: begin
        // Key and word latch on the same edge, so an accepted word sees the new key.
        if (key_load) begin
          e_nxt = key_e;
          n_nxt = key_n;
        end
        if (msg_valid) begin
          m_nxt     = msg_data;
          last_nxt  = msg_last;
          clr_nxt   = 1'b0;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        timer_nxt = TW'(SETTLE_CYCLES - 1);
        state_nxt = SETTLE;
      end
      SETTLE: begin
        if (timer == '0) begin
          comp_nxt  = 1'b1;
          state_nxt = START;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      START: begin
        timer_nxt = TW'(TIMEOUT_CYCLES - 1);
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        // enc_done takes priority over an expiring timer.
        if (enc_done) begin
          ctd_nxt   = enc_C;
          cte_nxt   = 1'b0;
          ctv_nxt   = 1'b1;
          ctl_nxt   = last_q;
          comp_nxt  = 1'b0;
          state_nxt = OUTPUT;
        end else if (timer == '0) begin
          ctd_nxt   = '0;
          cte_nxt   = 1'b1;
          terr_nxt  = 1'b1;
          ctv_nxt   = 1'b1;
          ctl_nxt   = last_q;
          comp_nxt  = 1'b0;
          state_nxt = OUTPUT;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      OUTPUT: begin
        if (ct_ready) begin
          ctv_nxt   = 1'b0;
          ctl_nxt   = 1'b0;
          cte_nxt   = 1'b0;
          wc_nxt    = last_q ? '0 : word_count + CNT_W'(1);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_q      <= 1'b0;
      timer       <= '0;
      enc_M       <= '0;
      enc_e       <= '0;
      enc_n       <= '0;
      enc_clr_n   <= 1'b1;
      enc_compute <= 1'b0;
      ct_valid    <= 1'b0;
      ct_data     <= '0;
      ct_last     <= 1'b0;
      ct_err      <= 1'b0;
      timeout_err <= 1'b0;
      word_count  <= '0;
    end else begin
      state       <= state_nxt;
      last_q      <= last_nxt;
      timer       <= timer_nxt;
      enc_M       <= m_nxt;
      enc_e       <= e_nxt;
      enc_n       <= n_nxt;
      enc_clr_n   <= clr_nxt;
      enc_compute <= comp_nxt;
      ct_valid    <= ctv_nxt;
      ct_data     <= ctd_nxt;
      ct_last     <= ctl_nxt;
      ct_err      <= cte_nxt;
      timeout_err <= terr_nxt;
      word_count  <= wc_nxt;
    end
  end

endmodule

// File: tb/tb_rsa_encrypt_sequencer.sv
// Bench for rsa_encrypt_sequencer: behavioural encryptor model plus a
// scoreboard of hand-computed ciphertexts checked by an independent monitor.
module tb_rsa_encrypt_sequencer;

  localparam int SETTLE = 2;
  localparam int TMO    = 16;
  localparam int CW     = 16;
  localparam int LAT    = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          key_load = 1'b0;
  logic [31:0]   key_e = '0, key_n = '0;
  logic          msg_valid = 1'b0;
  logic [31:0]   msg_data = '0;
  logic          msg_last = 1'b0;
  logic          msg_ready;
  logic          enc_clr_n, enc_compute;
  logic [31:0]   enc_M, enc_e, enc_n;
  logic [31:0]   enc_C;
  logic          enc_done;
  logic          ct_valid, ct_last, ct_err;
  logic [31:0]   ct_data;
  logic          ct_ready = 1'b1;
  logic          busy, timeout_err;
  logic [CW-1:0] word_count;

  always #5 clk = ~clk;

  rsa_encrypt_sequencer #(
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_load(key_load), .key_e(key_e), .key_n(key_n),
    .msg_valid(msg_valid), .msg_data(msg_data), .msg_last(msg_last), .msg_ready(msg_ready),
    .enc_clr_n(enc_clr_n), .enc_compute(enc_compute), .enc_M(enc_M), .enc_e(enc_e),
    .enc_n(enc_n), .enc_C(enc_C), .enc_done(enc_done), .ct_valid(ct_valid),
    .ct_data(ct_data), .ct_last(ct_last), .ct_err(ct_err), .ct_ready(ct_ready),
    .busy(busy), .timeout_err(timeout_err), .word_count(word_count)
  );

  // Encryptor model: done is a level that stays high until the next clear.
  logic never_done = 1'b0;
  int   mcnt;

  function automatic logic [31:0] modexp(input logic [31:0] m, input logic [31:0] e,
                                         input logic [31:0] n);
    logic [63:0] r, b;
    r = 64'd1;
    b = {32'd0, m} % {32'd0, n};
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * b) % {32'd0, n};
      b = (b * b) % {32'd0, n};
    end
    return r[31:0];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enc_done <= 1'b0;
      enc_C    <= '0;
      mcnt     <= 0;
    end else if (!enc_clr_n) begin
      enc_done <= 1'b0;
      mcnt     <= 0;
    end else if (enc_compute && !enc_done && !never_done) begin
      if (mcnt == LAT - 1) begin
        enc_done <= 1'b1;
        enc_C    <= modexp(enc_M, enc_e, enc_n);
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0]   d;
    logic          l;
    logic          e;
    logic [CW-1:0] wc;
  } exp_t;

  exp_t sb[$];

  task automatic push(input logic [31:0] d, input logic l, input logic e, input logic [CW-1:0] wc);
    exp_t x;
    x.d = d; x.l = l; x.e = e; x.wc = wc;
    sb.push_back(x);
  endtask

  // Monitor: pops on every ciphertext handshake, checks word_count one cycle later.
  logic          wc_pending = 1'b0;
  logic [CW-1:0] wc_exp;
  exp_t          cur;

  initial begin
    forever begin
      @(negedge clk);
      if (wc_pending) begin
        chk("word_count", 32'(word_count), 32'(wc_exp));
        wc_pending = 1'b0;
      end
      if (ct_valid) begin
        chk("msg_ready_while_ct", 32'(msg_ready), 32'd0);
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ct: got data %0d, expected no ciphertext", ct_data);
        end else if (ct_ready) begin
          cur = sb.pop_front();
          chk("ct_data", ct_data, cur.d);
          chk("ct_last", 32'(ct_last), 32'(cur.l));
          chk("ct_err", 32'(ct_err), 32'(cur.e));
          wc_exp     = cur.wc;
          wc_pending = 1'b1;
        end else begin
          chk("ct_data_stable", ct_data, sb[0].d);
          chk("ct_last_stable", 32'(ct_last), 32'(sb[0].l));
        end
      end
    end
  end

  // Call at posedge+#1; returns at posedge+#1 just after the accepting edge.
  task automatic send(input logic [31:0] m, input logic l, input logic kl);
    int t = 0;
    while (!msg_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!msg_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_wait: got msg_ready 0, expected 1 within 200 cycles");
    end
    msg_data  = m;
    msg_last  = l;
    msg_valid = 1'b1;
    key_load  = kl;
    @(posedge clk); #1;
    msg_valid = 1'b0;
    key_load  = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(posedge clk); #1;
    while ((busy || ct_valid) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (busy || ct_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: got busy %0d, expected 0 within 200 cycles", busy);
    end
  endtask

  task automatic wait_compute();
    int t = 0;
    while (!enc_compute && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!enc_compute) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_compute: got enc_compute 0, expected 1 within 50 cycles");
    end
  endtask

  // Cycle k is the k-th negedge after the accepting edge.
  task automatic measure(output int fc, output int cl, output int fv);
    fc = 0; cl = 0; fv = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (!enc_clr_n) cl++;
      if (enc_compute && fc == 0) fc = k;
      if (ct_valid) begin
        fv = k;
        break;
      end
    end
  endtask

  int fc, cl, fv;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_msg_ready", 32'(msg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clr_n", 32'(enc_clr_n), 32'd1);
    chk("rst_compute", 32'(enc_compute), 32'd0);
    chk("rst_ct_valid", 32'(ct_valid), 32'd0);
    chk("rst_ct_data", ct_data, 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Key load in the same cycle as the first accepted word.
    key_e = 32'd17;
    key_n = 32'd3233;
    push(32'd2790, 1'b1, 1'b0, 16'd0);
    send(32'd65, 1'b1, 1'b1);
    measure(fc, cl, fv);
    chk("compute_latency", fc, 32'd4);
    chk("clr_pulse_cycles", cl, 32'd1);
    chk("ct_valid_latency", fv, 32'd8);
    chk("key_n_loaded", enc_n, 32'd3233);
    wait_idle();

    // Three-word message; stale done from the previous word must be cleared.
    push(32'd855, 1'b0, 1'b0, 16'd1);
    send(32'd123, 1'b0, 1'b0);
    @(negedge clk);
    chk("msg_ready_busy", 32'(msg_ready), 32'd0);
    measure(fc, cl, fv);
    chk("stale_clr_pulse", cl, 32'd0);
    wait_idle();
    push(32'd0, 1'b0, 1'b0, 16'd2);
    send(32'd0, 1'b0, 1'b0);
    wait_idle();
    push(32'd1, 1'b1, 1'b0, 16'd0);
    send(32'd1, 1'b1, 1'b0);
    wait_idle();

    // Stale done: done still high from M=1, new word must produce 855.
    push(32'd855, 1'b1, 1'b0, 16'd0);
    send(32'd123, 1'b1, 1'b0);
    measure(fc, cl, fv);
    chk("stale2_clr_pulse", cl, 32'd1);
    wait_idle();

    // Backpressure with a competing word offered.
    ct_ready = 1'b0;
    push(32'd2790, 1'b1, 1'b0, 16'd0);
    send(32'd65, 1'b1, 1'b0);
    measure(fc, cl, fv);
    chk("bp_ct_valid_seen", 32'(ct_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      msg_data  = 32'd7;
      msg_last  = 1'b0;
      msg_valid = 1'b1;
      @(negedge clk);
      chk("bp_msg_ready", 32'(msg_ready), 32'd0);
    end
    @(posedge clk); #1;
    msg_valid = 1'b0;
    ct_ready  = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    chk("bp_idle", 32'(busy), 32'd0);
    chk("bp_ct_valid_drop", 32'(ct_valid), 32'd0);
    chk("bp_no_second_word", enc_M, 32'd65);

    // Timeout: model never finishes.
    never_done = 1'b1;
    push(32'd0, 1'b1, 1'b1, 16'd0);
    send(32'd5, 1'b1, 1'b0);
    measure(fc, cl, fv);
    chk("timeout_latency", fv, 32'd21);
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    wait_idle();
    never_done = 1'b0;
    push(32'd855, 1'b1, 1'b0, 16'd0);
    send(32'd123, 1'b1, 1'b0);
    wait_idle();
    chk("timeout_err_sticky", 32'(timeout_err), 32'd1);

    // key_load ignored while busy.
    push(32'd2790, 1'b1, 1'b0, 16'd0);
    send(32'd65, 1'b1, 1'b0);
    wait_compute();
    @(posedge clk); #1;
    key_e    = 32'd3;
    key_n    = 32'd9999;
    key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
    chk("busy_key_n_held", enc_n, 32'd3233);
    chk("busy_key_e_held", enc_e, 32'd17);
    key_e = 32'd17;
    key_n = 32'd3233;
    wait_idle();

    // Reset in the middle of WAIT_DONE; this word is abandoned.
    never_done = 1'b1;
    send(32'd123, 1'b1, 1'b0);
    wait_compute();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_compute", 32'(enc_compute), 32'd0);
    chk("mid_rst_clr_n", 32'(enc_clr_n), 32'd1);
    chk("mid_rst_ct_valid", 32'(ct_valid), 32'd0);
    chk("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("mid_rst_enc_n", enc_n, 32'd0);
    chk("mid_rst_enc_M", enc_M, 32'd0);
    chk("mid_rst_word_count", 32'(word_count), 32'd0);
    never_done = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    push(32'd2790, 1'b1, 1'b0, 16'd0);
    send(32'd65, 1'b1, 1'b1);
    wait_idle();
    chk("post_rst_timeout_err", 32'(timeout_err), 32'd0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rsa_encrypt_sequencer.md
Name: rsa_encrypt_sequencer

Overview:
- Upstream driver for the 32-bit RSA encryptor core.
- Accepts a stream of 32-bit plaintext words over a valid/ready interface and holds the public key (e, n).
- For each word it clears the encryptor, presents M/e/n with a level compute request, waits for done, and captures C.
- It then emits C on a valid/ready ciphertext stream with a last marker, so host logic never touches the core's handshake.

Parameters:
- SETTLE_CYCLES, 2: cycles between clear release and compute assertion (min 1).
- TIMEOUT_CYCLES, 1048576: max cycles in WAIT_DONE before abort.
- CNT_W, 16: width of word_count.

Ports:
- clk  in  1  system clock, all flops rising edge
- reset_n  in  1  asynchronous active-low reset
- key_load  in  1  load key_e/key_n (honoured only in IDLE)
- key_e  in  32  public exponent
- key_n  in  32  modulus
- msg_valid  in  1  plaintext word valid
- msg_data  in  32  plaintext word M
- msg_last  in  1  final word of message
- msg_ready  out  1  sequencer can accept a word
- enc_clr_n  out  1  active-low clear to encryptor, ANDed with reset_n at the core
- enc_compute  out  1  level compute request to encryptor
- enc_M, enc_e, enc_n  out  32 each  operands to encryptor, stable while enc_compute=1
- enc_C  in  32  encryptor result
- enc_done  in  1  encryptor done (level)
- ct_valid  out  1  ciphertext valid
- ct_data  out  32  ciphertext C
- ct_last  out  1  ciphertext belongs to last word
- ct_err  out  1  this word timed out; ct_data=0
- ct_ready  in  1  downstream accepts ciphertext
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky, set on any timeout
- word_count  out  CNT_W  words delivered in current message

Behaviour:
- Reset values (async, on reset_n=0, including mid-operation):
  - state=IDLE; all key/M registers=0; enc_clr_n=1; enc_compute=0.
  - ct_valid/ct_last/ct_err=0; ct_data=0; timeout_err=0; word_count=0.
  - The encryptor shares reset_n, so both restart together.
- All outputs are registered; msg_ready=(state==IDLE) and busy=(state!=IDLE) are decoded from the state register.
- Key: key_load=1 in IDLE latches key_e/key_n on that edge. Ignored in every other state. The key is held across words.
- Same-cycle key_load and msg handshake in IDLE: the key is latched first; the accepted word uses the new key.
- FSM:
  - IDLE: on msg_valid&msg_ready, latch M=msg_data and last=msg_last -> CLEAR.
  - CLEAR: enc_clr_n=0 for exactly one cycle -> SETTLE.
  - SETTLE: enc_clr_n=1; stay SETTLE_CYCLES cycles -> START.
  - START: enc_compute<=1; timeout counter<=0 -> WAIT_DONE.
  - WAIT_DONE: enc_compute held 1; counter increments each cycle.
    - enc_done=1: ct_data<=enc_C, ct_err<=0 -> OUTPUT.
    - Counter reaches TIMEOUT_CYCLES-1 without done: ct_data<=0, ct_err<=1, timeout_err<=1 -> OUTPUT.
    - Done wins over timeout in the same cycle.
  - OUTPUT: enc_compute<=0; ct_valid=1; ct_last=last.
    - On ct_valid&ct_ready: ct_valid<=0 -> IDLE.
    - word_count<=last ? 0 : word_count+1; wraps at 2^CNT_W.
- enc_done is sampled only in WAIT_DONE. Stale done in IDLE/CLEAR/SETTLE/START is ignored; the clear pulse guarantees done is low by START.
- Latency: handshake at edge 0 -> enc_clr_n low cycle 1 -> enc_compute high cycle 2+SETTLE_CYCLES. ct_valid rises one cycle after enc_done is sampled high.
- Throughput: one word in flight; msg_ready=0 from acceptance until ct handshake.
- ct_ready held high: OUTPUT lasts exactly one cycle. ct_data/ct_last/ct_err are stable while ct_valid=1 and ct_ready=0.
- msg_valid may drop or change while msg_ready=0 without effect.
- No range check on M: M>=n is encrypted as given. n<2 is not guarded; the host is responsible.

Test Plan:
- Key e=17, n=3233 loaded; send M=65 last=1, ct_ready=1 -> enc_compute rises 4 cycles after accept (SETTLE_CYCLES=2); ct_data=2790, ct_last=1, ct_err=0, word_count=0 after delivery.
- Same key, stream M=123, 0, 1 (last on 1), ct_ready=1 -> ct_data 855, 0, 1 in order; word_count 1, 2, then 0; msg_ready low throughout each word.
- Backpressure: ct_ready=0 for 10 cycles after ct_valid with M=65 -> ct_data=2790 stable, msg_ready=0, no second word accepted; then ct_ready=1 -> one-cycle handshake, IDLE.
- Timeout: encryptor model never asserts done, TIMEOUT_CYCLES=16 -> ct_valid after 16 cycles in WAIT_DONE with ct_data=0, ct_err=1, timeout_err=1 (stays 1 on the next good word).
- Stale done: model holds enc_done=1 until clear, second word M=123 -> ciphertext from previous word is not reused; enc_clr_n pulses low one cycle; result 855.
- Reset mid-WAIT_DONE and key_load while busy: reset_n low -> all outputs at reset values next cycle; key_load with key_n=9999 during WAIT_DONE -> enc_n stays 3233.
